pe_acc_drain: RTL and testbench

//  Result-side reader for the 14x14 weight-stationary INT8 systolic array: after a tile computes, it reads every PE's INT32 acc
//  and streams it out one array row per beat over a valid/ready interface.
//  - Sits between the PE grid and the output buffer / writeback path.
//  - After the last row is accepted, it pulses the PEs' sync clr so the next tile starts from zero.

---
 rtl/accel_pkg.sv | 18 +
 rtl/pe_acc_drain_if.sv | 17 +
 rtl/acc_lane_post.sv | 16 +
 rtl/pe_acc_drain.sv | 116 +++++++++++
 tb/tb_pe_acc_drain.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator types: array geometry, accumulator type, drain FSM states.
package accel_pkg;

  localparam int ACC_W      = 32;
  localparam int ARRAY_ROWS = 14;
  localparam int ARRAY_COLS = 14;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DRAIN,
    CLEAR,
    DONE
  } drain_state_e;

endpackage

// File: rtl/pe_acc_drain_if.sv
// Row-beat output stream of the accumulator drain.
// Handshake: a beat moves on a rising clk edge where m_valid && m_ready; while m_valid is high
// and m_ready low the master holds m_data/m_row/m_last stable; m_ready is ignored when m_valid is low.
interface pe_acc_drain_if #(
  parameter int COLS  = 14,
  parameter int ACC_W = 32,
  parameter int RW    = 4
);
  logic                  m_valid;
  logic                  m_ready;
  logic [COLS*ACC_W-1:0] m_data;
  logic [RW-1:0]         m_row;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_row, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_row, input m_last, output m_ready);
endinterface

// File: rtl/acc_lane_post.sv
// Per-lane post-processing of a drained accumulator.
// Build option PE_DRAIN_RELU_EN: clamp negative lanes to zero; otherwise bit-exact passthrough.
module acc_lane_post #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] i_acc,
  output logic signed [W-1:0] o_acc
);

`ifdef PE_DRAIN_RELU_EN
  assign o_acc = i_acc[W-1] ? '0 : i_acc;
`else
  assign o_acc = i_acc;
`endif

endmodule

// File: rtl/pe_acc_drain.sv
// Reads every PE accumulator after a tile and streams one array row per beat, then clears the PEs.
// Build option PE_DRAIN_RELU_EN selects ReLU lane post-processing (see acc_lane_post).
module pe_acc_drain
  import accel_pkg::*;
#(
  parameter int ROWS       = ARRAY_ROWS,
  parameter int COLS       = ARRAY_COLS,
  parameter int ACC_W      = accel_pkg::ACC_W,
  parameter int ACC_SETTLE = 2,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ROWS*COLS*ACC_W-1:0] acc_flat,
  output logic                    busy,
  output logic                    clr_out,
  output logic                    done,
  pe_acc_drain_if.master          m,
  output drain_state_e            dbg_state
);

  localparam int CW = (ACC_SETTLE > 1) ? $clog2(ACC_SETTLE) : 1;
  localparam int LW = COLS * ACC_W;

  drain_state_e   r_state;
  drain_state_e   w_state_nxt;
  logic [CW-1:0]  r_settle_cnt;
  logic [RW-1:0]  r_row;
  logic           r_valid;
  logic [LW-1:0]  r_data;

  logic           w_load;
  logic           w_drop;
  logic           w_xfer;
  logic [RW-1:0]  w_load_row;
  logic [LW-1:0]  w_row_raw;
  logic [LW-1:0]  w_row_post;

  assign w_xfer    = r_valid && m.m_ready;
  assign w_row_raw = acc_flat[w_load_row*LW +: LW];

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    acc_lane_post #(.W(ACC_W)) u_post (
      .i_acc (w_row_raw[c*ACC_W +: ACC_W]),
      .o_acc (w_row_post[c*ACC_W +: ACC_W])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_load_row  = '0;
    case (r_state)
      IDLE:   if (start) w_state_nxt = SETTLE;
      SETTLE: begin
        if (r_settle_cnt == CW'(ACC_SETTLE - 1)) begin
          w_load      = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The next row is loaded on the same edge the current one is accepted, so there is no bubble.
        if (w_xfer) begin
          if (r_row == RW'(ROWS - 1)) begin
            w_drop      = 1'b1;
            w_state_nxt = CLEAR;
          end else begin
            w_load     = 1'b1;
            w_load_row = r_row + 1'b1;
          end
        end
      end
      CLEAR:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_settle_cnt <= '0;
    else if (r_state == IDLE)   r_settle_cnt <= '0;
    else if (r_state == SETTLE) r_settle_cnt <= r_settle_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_row_post;
      r_row   <= w_load_row;
      r_valid <= 1'b1;
    end else if (w_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign busy      = (r_state != IDLE);
  assign clr_out   = (r_state == CLEAR);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

  assign m.m_valid = r_valid;
  assign m.m_data  = r_data;
  assign m.m_row   = r_row;
  assign m.m_last  = r_valid && (r_row == RW'(ROWS - 1));

endmodule

// File: tb/tb_pe_acc_drain.sv
// Directed bench for pe_acc_drain: tile model + beat scoreboard checked every cycle.
module tb_pe_acc_drain;
  import accel_pkg::*;

  localparam int R  = 14;
  localparam int C  = 14;
  localparam int W  = 32;
  localparam int LW = C * W;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [R*C*W-1:0]   acc_flat;
  logic               busy;
  logic               clr_out;
  logic               done;
  drain_state_e       dbg_state;

  pe_acc_drain_if #(.COLS(C), .ACC_W(W), .RW(4)) m_if ();

  pe_acc_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .acc_flat  (acc_flat),
    .busy      (busy),
    .clr_out   (clr_out),
    .done      (done),
    .m         (m_if),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // tile model and scoreboard
  logic signed [W-1:0] acc_m [R][C];
  logic [3:0]          exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  int n_clr    = 0;
  int n_done   = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] exp_row(input int r);
    logic [LW-1:0]       v;
    logic signed [W-1:0] a;
    v = '0;
    for (int c = 0; c < C; c++) begin
      a = acc_m[r][c];
`ifdef PE_DRAIN_RELU_EN
      if (a < 0) a = '0;
`endif
      v[c*W +: W] = a;
    end
    return v;
  endfunction

  task automatic apply_acc();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        acc_flat[(r*C+c)*W +: W] = acc_m[r][c];
  endtask

  task automatic push_tile();
    for (int r = 0; r < R; r++) exp_q.push_back(4'(r));
  endtask

  // compare process: every beat must be the next expected row, held while stalled
  initial begin
    logic          prev_stall;
    logic [LW-1:0] prev_data;
    logic [3:0]    prev_row;
    logic [3:0]    hr;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_row   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          chk("stall_hold", {m_if.m_valid, m_if.m_row, m_if.m_data}, {1'b1, prev_row, prev_data});
        if (m_if.m_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            hr = exp_q[0];
            chk("beat_row", m_if.m_row, hr);
            chk("beat_data", m_if.m_data, exp_row(int'(hr)));
            chk("beat_last", m_if.m_last, hr == 4'd13);
            if (m_if.m_ready) begin
              void'(exp_q.pop_front());
              n_beats++;
            end
          end
        end else if (m_if.m_last) begin
          chk("last_without_valid", m_if.m_last, 0);
        end
        if (clr_out) begin
          n_clr++;
          chk("clr_after_last_beat", {m_if.m_valid, exp_q.size() == 0}, 2'b01);
        end
        if (done) n_done++;
        prev_stall = m_if.m_valid && !m_if.m_ready;
        prev_data  = m_if.m_data;
        prev_row   = m_if.m_row;
      end
    end
  end

  // driver: cycle k starts #1 after a rising edge; mode 0 = ready always, 1 = ready every 3rd cycle
  task automatic run(input int mode, input int budget, input int restart_at, output int done_cyc);
    done_cyc = -1;
    for (int k = 0; k < budget && done_cyc < 0; k++) begin
      @(negedge clk);
      if (done) done_cyc = k;
      @(posedge clk); #1;
      start      = (k + 1 == restart_at);
      m_if.m_ready = (mode == 0) ? 1'b1 : ((k + 1) % 3 == 0);
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int b0, c0, d0, dc, first_v, clr_k, done_k, n_c, n_d, busy_err, nz;
    logic [W-1:0] lane5_b0, lane13_b13;
    logic [3:0]   row_b13;
    logic         last_b13;
    logic [LW-1:0] d;

    // 1: reset holds everything at zero
    rst_n = 1'b0;
    start = 1'b0;
    m_if.m_ready = 1'b0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) acc_m[r][c] = $urandom;
    apply_acc();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, clr_out, done, m_if.m_valid, m_if.m_last, m_if.m_row, m_if.m_data}, '0);
    chk("reset_state", dbg_state, IDLE);
    tick();
    rst_n = 1'b1;
    nz = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ({busy, clr_out, done, m_if.m_valid, m_if.m_last, m_if.m_row, m_if.m_data} != '0) nz++;
    end
    chk("idle_after_reset", nz, 0);

    // 2: full-throughput drain with cycle-exact timing
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) acc_m[r][c] = r * 100 + c;
    apply_acc();
    push_tile();
    tick();
    start = 1'b1;
    m_if.m_ready = 1'b1;
    first_v = -1; clr_k = -1; done_k = -1; n_c = 0; n_d = 0; busy_err = 0;
    lane5_b0 = '0; lane13_b13 = '0; row_b13 = '0; last_b13 = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (m_if.m_valid && first_v < 0) first_v = k;
      if (clr_out) begin clr_k = k; n_c++; end
      if (done) begin done_k = k; n_d++; end
      if (busy != (k >= 1 && k <= 18)) busy_err++;
      if (k == 3) begin d = m_if.m_data; lane5_b0 = d[5*W +: W]; end
      if (k == 16) begin
        d = m_if.m_data; lane13_b13 = d[13*W +: W];
        row_b13 = m_if.m_row; last_b13 = m_if.m_last;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("first_valid_cycle", first_v, 3);
    chk("clr_cycle", {clr_k, n_c}, {32'd17, 32'd1});
    chk("done_cycle", {done_k, n_d}, {32'd18, 32'd1});
    chk("busy_window", busy_err, 0);
    chk("beat0_lane5", lane5_b0, 32'd5);
    chk("beat13_lane13", lane13_b13, 32'd1313);
    chk("beat13_row_last", {row_b13, last_b13}, {4'd13, 1'b1});
    chk("queue_drained_full", exp_q.size(), 0);

    // 3: backpressure, ready 1,0,0 repeating
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) acc_m[r][c] = $urandom;
    apply_acc();
    push_tile();
    b0 = n_beats; d0 = n_done; c0 = n_clr;
    start = 1'b1;
    m_if.m_ready = 1'b1;
    run(1, 200, -1, dc);
    chk("bp_beats", n_beats - b0, 14);
    chk("bp_done_clr", {n_done - d0, n_clr - c0}, {32'd1, 32'd1});
    chk("queue_drained_bp", exp_q.size(), 0);

    // 4: start during DRAIN ignored, start right after done accepted
    push_tile();
    b0 = n_beats; d0 = n_done;
    start = 1'b1;
    m_if.m_ready = 1'b1;
    run(0, 100, 6, dc);
    chk("ignored_start_done_cycle", dc, 18);
    push_tile();
    start = 1'b1;
    run(0, 100, -1, dc);
    chk("restart_after_done_cycle", dc, 18);
    chk("restart_beats_done", {n_beats - b0, n_done - d0}, {32'd28, 32'd2});
    chk("queue_drained_restart", exp_q.size(), 0);

    // 5: reset after beat 5 accepted
    push_tile();
    b0 = n_beats; d0 = n_done; c0 = n_clr;
    start = 1'b1;
    nz = 0;
    for (int k = 0; k < 60 && (n_beats - b0) < 6; k++) begin
      @(negedge clk);
      nz = n_beats - b0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("mid_beats_before_reset", n_beats - b0, 6);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_reset_outputs", {m_if.m_valid, busy, clr_out, done}, 4'b0000);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("mid_reset_no_clr_done", {n_clr - c0, n_done - d0}, 64'd0);
    push_tile();
    start = 1'b1;
    run(0, 100, -1, dc);
    chk("fresh_drain_after_reset", {dc, n_beats - b0}, {32'd18, 32'd20});

    // 6: signed extremes / ReLU
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) acc_m[r][c] = '0;
    acc_m[0][0] = -32'sd5;
    acc_m[0][1] = 32'h7FFF_FFFF;
    acc_m[0][2] = 32'h8000_0000;
    apply_acc();
    push_tile();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10 && !m_if.m_valid; k++) @(negedge clk);
    d = m_if.m_data;
`ifdef PE_DRAIN_RELU_EN
    chk("relu_lanes", {d[0 +: W], d[W +: W], d[2*W +: W]}, {32'h0, 32'h7FFF_FFFF, 32'h0});
`else
    chk("signed_lanes", {d[0 +: W], d[W +: W], d[2*W +: W]}, {32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000});
`endif
    run(0, 100, -1, dc);
    chk("queue_drained_signed", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
